// File: rtl/panda_risc_v_gpr_file.sv
// rtl/panda_risc_v_gpr_file.sv - x0..x31 register file with two decoder read ports and a shared fetch-unit read port
// Optional feature: define PANDA_RISC_V_REG_FILE_WR_BYPASS_EN to forward same-cycle write data to reads.
module panda_risc_v_gpr_file #(
  parameter real         simulation_delay = 1,
  parameter integer      starve_thr       = 4,
  parameter logic [31:0] sp_rst_v         = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        sys_reset_req,
  input  logic        dcd_reg_file_rd_p0_req,
  input  logic [4:0]  dcd_reg_file_rd_p0_addr,
  output logic        dcd_reg_file_rd_p0_grant,
  output logic [31:0] dcd_reg_file_rd_p0_dout,
  input  logic        dcd_reg_file_rd_p1_req,
  input  logic [4:0]  dcd_reg_file_rd_p1_addr,
  output logic        dcd_reg_file_rd_p1_grant,
  output logic [31:0] dcd_reg_file_rd_p1_dout,
  input  logic        ifu_reg_file_rd_req,
  input  logic [4:0]  ifu_reg_file_rd_addr,
  output logic        ifu_reg_file_rd_grant,
  output logic [31:0] ifu_reg_file_rd_dout,
  input  logic        reg_file_wen,
  input  logic [4:0]  reg_file_waddr,
  input  logic [31:0] reg_file_din
);

  // Update delay is a simulation-only notion; flops here are modelled without it.
  if (simulation_delay < 0.0) begin : g_negative_delay_ignored
  end

  localparam logic [3:0] thr = 4'(starve_thr);

  logic [31:0] regs [1:31];
  logic [3:0]  starve_cnt;
  logic        dcd_forced;

  // Register storage; x2 resets to the configured stack pointer, x0 is never stored.
  always_ff @(posedge clk) begin
    if (sys_reset_req) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= (i == 2) ? sp_rst_v : 32'h0;
      end
    end else if (reg_file_wen && (reg_file_waddr != 5'd0)) begin
      regs[reg_file_waddr] <= reg_file_din;
    end
  end

  // Read value for one index, including x0 = 0 and optional write forwarding.
  function automatic logic [31:0] rd_val(input logic [4:0] a);
    logic [31:0] v;
    if (a == 5'd0) begin
      v = 32'h0;
    end else begin
      v = regs[a];
`ifdef PANDA_RISC_V_REG_FILE_WR_BYPASS_EN
      if (reg_file_wen && (reg_file_waddr == a)) begin
        v = reg_file_din;
      end
`endif
    end
    return v;
  endfunction

  assign dcd_forced = (starve_cnt == thr);

  // Port #0 arbitration: fetch unit wins unless the decoder has been starved long enough.
  always_comb begin
    dcd_reg_file_rd_p0_grant = 1'b0;
    ifu_reg_file_rd_grant    = 1'b0;
    dcd_reg_file_rd_p1_grant = 1'b0;
    if (!sys_reset_req) begin
      dcd_reg_file_rd_p0_grant = dcd_reg_file_rd_p0_req & (~ifu_reg_file_rd_req | dcd_forced);
      ifu_reg_file_rd_grant    = ifu_reg_file_rd_req & ~(dcd_reg_file_rd_p0_req & dcd_forced);
      dcd_reg_file_rd_p1_grant = dcd_reg_file_rd_p1_req;
    end
  end

  // Read data is zeroed whenever its port is not granted.
  always_comb begin
    dcd_reg_file_rd_p0_dout = 32'h0;
    dcd_reg_file_rd_p1_dout = 32'h0;
    ifu_reg_file_rd_dout    = 32'h0;
    if (dcd_reg_file_rd_p0_grant) dcd_reg_file_rd_p0_dout = rd_val(dcd_reg_file_rd_p0_addr);
    if (dcd_reg_file_rd_p1_grant) dcd_reg_file_rd_p1_dout = rd_val(dcd_reg_file_rd_p1_addr);
    if (ifu_reg_file_rd_grant)    ifu_reg_file_rd_dout    = rd_val(ifu_reg_file_rd_addr);
  end

  // Count consecutive denied decoder cycles on port #0, saturating at the threshold.
  always_ff @(posedge clk) begin
    if (sys_reset_req) begin
      starve_cnt <= 4'd0;
    end else if (dcd_reg_file_rd_p0_req && !dcd_reg_file_rd_p0_grant) begin
      starve_cnt <= dcd_forced ? thr : starve_cnt + 4'd1;
    end else begin
      starve_cnt <= 4'd0;
    end
  end

endmodule

// File: tb/tb_panda_risc_v_gpr_file.sv
// tb/tb_panda_risc_v_gpr_file.sv - randomized self-checking bench for panda_risc_v_gpr_file
module tb_panda_risc_v_gpr_file;

  localparam int          THR = 4;
  localparam logic [31:0] SP  = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p1_req, f_req, wen;
  logic [4:0]  p0_addr, p1_addr, f_addr, waddr;
  logic [31:0] din;
  logic        p0_grant, p1_grant, f_grant;
  logic [31:0] p0_dout, p1_dout, f_dout;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: architectural register values and the current denied-request streak of the decoder.
  logic [31:0] m_regs [0:31];
  int          m_streak;
  bit          m_valid = 1'b0;

  always #5 clk = ~clk;

  panda_risc_v_gpr_file #(
    .simulation_delay(1),
    .starve_thr(THR),
    .sp_rst_v(SP)
  ) dut (
    .clk(clk),
    .sys_reset_req(rst),
    .dcd_reg_file_rd_p0_req(p0_req),
    .dcd_reg_file_rd_p0_addr(p0_addr),
    .dcd_reg_file_rd_p0_grant(p0_grant),
    .dcd_reg_file_rd_p0_dout(p0_dout),
    .dcd_reg_file_rd_p1_req(p1_req),
    .dcd_reg_file_rd_p1_addr(p1_addr),
    .dcd_reg_file_rd_p1_grant(p1_grant),
    .dcd_reg_file_rd_p1_dout(p1_dout),
    .ifu_reg_file_rd_req(f_req),
    .ifu_reg_file_rd_addr(f_addr),
    .ifu_reg_file_rd_grant(f_grant),
    .ifu_reg_file_rd_dout(f_dout),
    .reg_file_wen(wen),
    .reg_file_waddr(waddr),
    .reg_file_din(din)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef PANDA_RISC_V_REG_FILE_WR_BYPASS_EN
    if (wen && !rst && waddr == a) return din;
`endif
    return m_regs[a];
  endfunction

  // Expected grants derived from the priority rule: decoder wins only once starved THR times in a row.
  function automatic logic exp_d_grant();
    if (rst || !p0_req) return 1'b0;
    return !f_req || (m_streak == THR);
  endfunction

  function automatic logic exp_f_grant();
    if (rst || !f_req) return 1'b0;
    return !(p0_req && m_streak == THR);
  endfunction

  // Advance the reference on every clock edge using the inputs present at that edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= (i == 2) ? SP : 32'h0;
      m_streak <= 0;
      m_valid  <= 1'b1;
    end else begin
      if (wen && waddr != 5'd0) m_regs[waddr] <= din;
      if (p0_req && !exp_d_grant()) m_streak <= (m_streak >= THR) ? THR : m_streak + 1;
      else m_streak <= 0;
    end
  end

  // Compare every output against the reference mid-cycle.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("p0_grant", {31'h0, p0_grant}, {31'h0, exp_d_grant()});
      chk("f_grant",  {31'h0, f_grant},  {31'h0, exp_f_grant()});
      chk("p1_grant", {31'h0, p1_grant}, {31'h0, p1_req & ~rst});
      chk("p0_dout", p0_dout, exp_d_grant() ? exp_rd(p0_addr) : 32'h0);
      chk("f_dout",  f_dout,  exp_f_grant() ? exp_rd(f_addr)  : 32'h0);
      chk("p1_dout", p1_dout, (p1_req && !rst) ? exp_rd(p1_addr) : 32'h0);
      chk("no_double_grant", {31'h0, p0_grant & f_grant}, 32'h0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p0_req = 0; p1_req = 0; f_req = 0; wen = 0;
    p0_addr = 0; p1_addr = 0; f_addr = 0; waddr = 0; din = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    p0_req = 1; p1_req = 1; f_req = 1;
    p0_addr = 5'd2; p1_addr = 5'd2; f_addr = 5'd2;
    step();
    #1;
    chk("rst_p0_grant", {31'h0, p0_grant}, 32'h0);
    chk("rst_p1_grant", {31'h0, p1_grant}, 32'h0);
    chk("rst_f_grant",  {31'h0, f_grant},  32'h0);
    chk("rst_p1_dout",  p1_dout, 32'h0);
    step();

    rst = 0; idle();
    p1_req = 1; p1_addr = 5'd2; p0_req = 1; p0_addr = 5'd5;
    #1;
    chk("sp_reset_value", p1_dout, 32'h0000_2000);
    chk("x5_reset_value", p0_dout, 32'h0);

    step(); idle();
    wen = 1; waddr = 5'd7; din = 32'hDEAD_BEEF;
    step(); idle();
    p0_req = 1; p0_addr = 5'd7; p1_req = 1; p1_addr = 5'd7;
    #1;
    chk("x7_p0", p0_dout, 32'hDEAD_BEEF);
    chk("x7_p1", p1_dout, 32'hDEAD_BEEF);
    chk("x7_p0_grant", {31'h0, p0_grant}, 32'h1);

    step(); idle();
    wen = 1; waddr = 5'd0; din = 32'h1234;
    step(); idle();
    p1_req = 1; p1_addr = 5'd0;
    #1;
    chk("x0_reads_zero", p1_dout, 32'h0);

    step(); idle();
    wen = 1; waddr = 5'd9; din = 32'hA5A5_A5A5; p1_req = 1; p1_addr = 5'd9;
    #1;
`ifdef PANDA_RISC_V_REG_FILE_WR_BYPASS_EN
    chk("x9_same_cycle", p1_dout, 32'hA5A5_A5A5);
`else
    chk("x9_same_cycle", p1_dout, 32'h0);
`endif
    step(); idle();
    p1_req = 1; p1_addr = 5'd9;
    #1;
    chk("x9_next_cycle", p1_dout, 32'hA5A5_A5A5);

    step(); idle();
    for (int c = 1; c <= 6; c++) begin
      p0_req = 1; f_req = 1; p0_addr = 5'd7; f_addr = 5'd9;
      #1;
      chk($sformatf("starve_d_c%0d", c), {31'h0, p0_grant}, {31'h0, c == 5});
      chk($sformatf("starve_f_c%0d", c), {31'h0, f_grant},  {31'h0, c != 5});
      step();
    end

    idle();
    wen = 1; waddr = 5'd3; din = 32'h55;
    step();
    idle();
    p0_req = 1; f_req = 1;
    step(); step();
    rst = 1; wen = 1; waddr = 5'd3; din = 32'h77;
    step();
    rst = 0; idle();
    p1_req = 1; p1_addr = 5'd3;
    #1;
    chk("x3_after_reset", p1_dout, 32'h0);
    for (int c = 1; c <= 5; c++) begin
      p0_req = 1; f_req = 1;
      #1;
      if (c >= 4) chk($sformatf("post_rst_d_c%0d", c), {31'h0, p0_grant}, {31'h0, c == 5});
      step();
    end

    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 63) == 0);
      p0_req  = $urandom_range(0, 1);
      p1_req  = $urandom_range(0, 1);
      f_req   = ($urandom_range(0, 3) != 0);
      wen     = $urandom_range(0, 1);
      waddr   = 5'($urandom_range(0, 31));
      din     = $urandom;
      p0_addr = 5'($urandom_range(0, 31));
      f_addr  = 5'($urandom_range(0, 31));
      p1_addr = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      step();
    end

    idle();
    rst = 0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
